input_direction_arbiter: RTL and testbench

INPUT_DIRECTION_ARBITER -- requirements
Module: input_direction_arbiter

---
 rtl/input_direction_arbiter_if.sv | 29 ++
 rtl/input_direction_arbiter.sv | 169 ++++++++++++++++
 tb/tb_input_direction_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/input_direction_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_direction_arbiter_if
//  Description : Bundle of player-input and committed-direction signals for
//                input_direction_arbiter. The master side drives buttons,
//                keyboard bytes and the frame tick; the slave side returns
//                the committed direction.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_direction_arbiter_if;
    logic [3:0] key_n;            // raw active-low buttons: [0]=up [1]=down [2]=left [3]=right
    logic       ps2_key_pressed;  // one-cycle strobe, new keyboard byte
    logic [7:0] ps2_key_data;     // scan-code byte, valid with the strobe
    logic       tick;             // game-frame commit strobe
    logic [3:0] dir;              // committed one-hot direction
    logic       dir_valid;        // a direction has been committed
    logic       dir_changed;      // commit changed dir

    modport master (
        output key_n, ps2_key_pressed, ps2_key_data, tick,
        input  dir, dir_valid, dir_changed
    );

    modport slave (
        input  key_n, ps2_key_pressed, ps2_key_data, tick,
        output dir, dir_valid, dir_changed
    );
endinterface
`default_nettype wire

// File: rtl/input_direction_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : input_direction_arbiter
//  Description : Merges debounced pushbuttons and (optionally) PS2 arrow keys
//                into one pending direction request that is committed on
//                each game-frame tick.
//                Optional feature macro: PS2_INPUT_EN builds the PS2
//                scan-code decoder; without it the PS2 inputs are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_direction_arbiter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PS2_TIMEOUT     = 1000000
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input_direction_arbiter_if.slave bus
);

    localparam int                c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_press;
    logic [3:0] w_btn_req;
    logic [3:0] w_kbd_req;

    logic [3:0] r_pend;
    logic       r_pend_v;
    logic [3:0] r_dir;
    logic       r_dir_v;
    logic       r_dir_chg;

    // Two-flop synchronizer; resets to "released" so held buttons stay quiet
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= bus.key_n;
            r_sync2 <= r_sync1;
        end
    end

    // One debouncer per button; a press is reported on the cycle the
    // debounced state is about to flip from released to pressed
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic              r_deb_st;
        logic [c_DB_W-1:0] r_cnt;

        // Count consecutive cycles the synchronized input disagrees with the debounced state
        always_ff @(posedge clock) begin
            if (reset) begin
                r_deb_st <= 1'b1;
                r_cnt    <= '0;
            end else if (r_sync2[gi] != r_deb_st) begin
                if (r_cnt == c_DB_MAX) begin
                    r_deb_st <= r_sync2[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_press[gi] = r_deb_st && !r_sync2[gi] && (r_cnt == c_DB_MAX);
    end

    // Lowest index wins among simultaneous presses: up > down > left > right
    assign w_btn_req = w_press & (~w_press + 4'd1);

`ifdef PS2_INPUT_EN
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_EXT     = 2'd1;
    localparam logic [1:0] c_ST_BRK     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    localparam int                c_TO_W   = (PS2_TIMEOUT > 1) ? $clog2(PS2_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(PS2_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [c_TO_W-1:0] r_to_cnt;

    // Extended arrow scan codes produce a request straight from the EXT state
    always_comb begin
        w_kbd_req = 4'b0000;
        if (bus.ps2_key_pressed && (r_state == c_ST_EXT)) begin
            case (bus.ps2_key_data)
                8'h75:   w_kbd_req = 4'b0001;
                8'h72:   w_kbd_req = 4'b0010;
                8'h6B:   w_kbd_req = 4'b0100;
                8'h74:   w_kbd_req = 4'b1000;
                default: w_kbd_req = 4'b0000;
            endcase
        end
    end

    // Scan-code prefix tracker with idle timeout to drop stale partial sequences
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_to_cnt <= '0;
        end else if (bus.ps2_key_pressed) begin
            r_to_cnt <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.ps2_key_data == 8'hE0)      r_state <= c_ST_EXT;
                    else if (bus.ps2_key_data == 8'hF0) r_state <= c_ST_BRK;
                    else                                r_state <= c_ST_IDLE;
                end
                c_ST_EXT: begin
                    if (bus.ps2_key_data == 8'hF0) r_state <= c_ST_EXT_BRK;
                    else                           r_state <= c_ST_IDLE;
                end
                default:   r_state <= c_ST_IDLE;
            endcase
        end else if (r_state != c_ST_IDLE) begin
            if (r_to_cnt == c_TO_MAX) begin
                r_state  <= c_ST_IDLE;
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_ps2;

    assign w_kbd_req    = 4'b0000;
    assign w_unused_ps2 = ^{bus.ps2_key_pressed, bus.ps2_key_data};
`endif

    // Pending request (buttons beat keyboard) and commit on tick; a request
    // arriving with the tick overwrites the cleared slot and waits for the next tick
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend    <= 4'b0000;
            r_pend_v  <= 1'b0;
            r_dir     <= 4'b0000;
            r_dir_v   <= 1'b0;
            r_dir_chg <= 1'b0;
        end else begin
            r_dir_chg <= 1'b0;
            if (bus.tick && r_pend_v) begin
                r_dir     <= r_pend;
                r_dir_v   <= 1'b1;
                r_dir_chg <= (r_pend != r_dir);
                r_pend    <= 4'b0000;
                r_pend_v  <= 1'b0;
            end
            if (|w_btn_req) begin
                r_pend   <= w_btn_req;
                r_pend_v <= 1'b1;
            end else if (|w_kbd_req) begin
                r_pend   <= w_kbd_req;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign bus.dir         = r_dir;
    assign bus.dir_valid   = r_dir_v;
    assign bus.dir_changed = r_dir_chg;

endmodule
`default_nettype wire

// File: tb/tb_input_direction_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_direction_arbiter
//  Description : Directed bench for input_direction_arbiter with a
//                cycle-level reference model and literal checkpoints.
//                Expectations follow the PS2_INPUT_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_direction_arbiter;

    localparam int TB_DB = 4;
    localparam int TB_TO = 16;
`ifdef PS2_INPUT_EN
    localparam bit c_PS2 = 1'b1;
`else
    localparam bit c_PS2 = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    input_direction_arbiter_if ifc ();

    input_direction_arbiter #(
        .DEBOUNCE_CYCLES (TB_DB),
        .PS2_TIMEOUT     (TB_TO)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]       m_raw_d1, m_raw_d2;   // raw buttons delayed by one and two edges
    logic [TB_DB-1:0] m_hist [4];           // last TB_DB synchronized samples per button
    logic [3:0]       m_deb;
    logic [3:0]       m_pend;
    logic             m_pv;
    logic [3:0]       m_dir;
    logic             m_dv;
    logic             m_dc;
    bit               m_e0, m_f0;           // prefix bytes seen
    int               m_quiet;              // edges since last byte while a prefix is held

    always @(posedge clk) begin
        logic [3:0] press, btn, kbd;
        bit         committed;
        if (rst) begin
            m_raw_d1 = 4'hF; m_raw_d2 = 4'hF; m_deb = 4'hF;
            for (int i = 0; i < 4; i++) m_hist[i] = '1;
            m_pend = 0; m_pv = 0; m_dir = 0; m_dv = 0; m_dc = 0;
            m_e0 = 0; m_f0 = 0; m_quiet = 0;
        end else begin
            committed = 0;
            m_dc = 0;
            if (ifc.tick && m_pv) begin
                m_dc = (m_pend != m_dir);
                m_dir = m_pend; m_dv = 1; committed = 1;
            end
            // a button flips once its last TB_DB synchronized samples all oppose the debounced level
            press = 0;
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = {m_hist[i][TB_DB-2:0], m_raw_d2[i]};
                if (m_hist[i] == {TB_DB{~m_deb[i]}}) begin
                    m_deb[i] = ~m_deb[i];
                    if (m_deb[i] == 1'b0) press[i] = 1'b1;
                end
            end
            m_raw_d2 = m_raw_d1;
            m_raw_d1 = ifc.key_n;
            btn = 0;
            for (int i = 3; i >= 0; i--) if (press[i]) btn = 4'b0001 << i;
            kbd = 0;
            if (c_PS2) begin
                if (ifc.ps2_key_pressed) begin
                    m_quiet = 0;
                    if (m_f0) begin
                        m_e0 = 0; m_f0 = 0;
                    end else if (m_e0) begin
                        m_e0 = 0;
                        case (ifc.ps2_key_data)
                            8'h75: kbd = 4'b0001;
                            8'h72: kbd = 4'b0010;
                            8'h6B: kbd = 4'b0100;
                            8'h74: kbd = 4'b1000;
                            8'hF0: begin m_e0 = 1; m_f0 = 1; end
                            default: ;
                        endcase
                    end else if (ifc.ps2_key_data == 8'hE0) m_e0 = 1;
                    else if (ifc.ps2_key_data == 8'hF0) m_f0 = 1;
                end else if (m_e0 || m_f0) begin
                    m_quiet++;
                    if (m_quiet == TB_TO) begin m_e0 = 0; m_f0 = 0; m_quiet = 0; end
                end
            end
            if (btn != 0)      begin m_pend = btn; m_pv = 1; end
            else if (kbd != 0) begin m_pend = kbd; m_pv = 1; end
            else if (committed) begin m_pend = 0; m_pv = 0; end
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        chk("dir", ifc.dir, m_dir);
        chk("dir_valid", {3'b0, ifc.dir_valid}, {3'b0, m_dv});
        chk("dir_changed", {3'b0, ifc.dir_changed}, {3'b0, m_dc});
        chk("dir_onehot", {3'b0, ($countones(ifc.dir) <= 1)}, 4'b0001);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); ifc.ps2_key_pressed = 1'b1; ifc.ps2_key_data = b;
        @(negedge clk); ifc.ps2_key_pressed = 1'b0;
    endtask

    task automatic do_tick(input string nm, input logic [3:0] e_dir, input logic e_dv, input logic e_dc);
        @(negedge clk); ifc.tick = 1'b1;
        @(posedge clk); #2;
        chk({nm, "_dir"}, ifc.dir, e_dir);
        chk({nm, "_valid"}, {3'b0, ifc.dir_valid}, {3'b0, e_dv});
        chk({nm, "_chg"}, {3'b0, ifc.dir_changed}, {3'b0, e_dc});
        @(negedge clk); ifc.tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        ifc.key_n = 4'b1111; ifc.ps2_key_pressed = 1'b0; ifc.ps2_key_data = 8'h00; ifc.tick = 1'b0;
        idle(3);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("reset_dir", ifc.dir, 4'b0000);
        chk("reset_flags", {2'b0, ifc.dir_valid, ifc.dir_changed}, 4'b0000);

        // hold up, commit it
        @(negedge clk); ifc.key_n = 4'b1110;
        idle(10);
        do_tick("up_press", 4'b0001, 1'b1, 1'b1);
        @(negedge clk); ifc.key_n = 4'b1111;
        idle(10);

        // bouncing down button never settles
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); ifc.key_n = ((c / 2) % 2 == 0) ? 4'b1101 : 4'b1111;
        end
        @(negedge clk); ifc.key_n = 4'b1111;
        idle(6);
        do_tick("bounce", 4'b0001, 1'b1, 1'b0);

        // keyboard left, then a left release sequence
        send_byte(8'hE0); send_byte(8'h6B);
        do_tick("kbd_left", c_PS2 ? 4'b0100 : 4'b0001, 1'b1, c_PS2);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        do_tick("kbd_break", c_PS2 ? 4'b0100 : 4'b0001, 1'b1, 1'b0);

        // keyboard up and button right in the same cycle: button wins
        @(negedge clk); ifc.key_n = 4'b0111; ifc.ps2_key_pressed = 1'b1; ifc.ps2_key_data = 8'hE0;
        @(negedge clk); ifc.ps2_key_pressed = 1'b0;
        idle(3);
        @(negedge clk); ifc.ps2_key_pressed = 1'b1; ifc.ps2_key_data = 8'h75;
        @(negedge clk); ifc.ps2_key_pressed = 1'b0;
        idle(2);
        do_tick("collide", 4'b1000, 1'b1, 1'b1);
        @(negedge clk); ifc.key_n = 4'b1111;
        idle(8);

        // prefix times out, later 6B is a plain byte
        send_byte(8'hE0);
        idle(20);
        send_byte(8'h6B);
        do_tick("timeout", 4'b1000, 1'b1, 1'b0);

        // request arriving with the tick waits for the next tick
        @(negedge clk); ifc.key_n = 4'b1101;
        idle(4);
        @(negedge clk); ifc.tick = 1'b1;
        @(posedge clk); #2;
        chk("same_tick_dir", ifc.dir, 4'b1000);
        chk("same_tick_chg", {3'b0, ifc.dir_changed}, 4'b0000);
        @(negedge clk); ifc.tick = 1'b0;
        idle(2);
        do_tick("next_tick", 4'b0010, 1'b1, 1'b1);
        @(negedge clk); ifc.key_n = 4'b1111;
        idle(8);

        // reset right after a prefix byte discards it
        send_byte(8'hE0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("midrst_dir", ifc.dir, 4'b0000);
        chk("midrst_flags", {2'b0, ifc.dir_valid, ifc.dir_changed}, 4'b0000);
        send_byte(8'h6B);
        do_tick("after_rst", 4'b0000, 1'b0, 1'b0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
